// File: rtl/ffs_pkg.sv
// ffs_pkg: limb geometry, default field prime and FSM encoding shared by the field arithmetic blocks
package ffs_pkg;
  localparam int LIMB_W = 64;
  localparam int NLIMB = 4;
  localparam int W = LIMB_W * NLIMB;
  localparam int CNT_W = $clog2(NLIMB);
  localparam logic [W-1:0] P_DEFAULT =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  typedef enum logic [1:0] {IDLE, SUB, CORR} state_e;
endpackage

// File: rtl/ffs_limb_addsub.sv
// limb_addsub: one 64-bit limb add (sub_i=0) or subtract (sub_i=1) with carry/borrow in and out
module limb_addsub
  import ffs_pkg::*;
(
  input  logic              sub_i,
  input  logic [LIMB_W-1:0] x_i,
  input  logic [LIMB_W-1:0] y_i,
  input  logic              ci_i,
  output logic [LIMB_W-1:0] s_o,
  output logic              co_o
);
  logic [LIMB_W:0] r_d;
  always_comb begin
    r_d = sub_i ? {1'b0, x_i} - {1'b0, y_i} - {{LIMB_W{1'b0}}, ci_i}
                : {1'b0, x_i} + {1'b0, y_i} + {{LIMB_W{1'b0}}, ci_i};
    {co_o, s_o} = r_d;
  end
endmodule

// File: rtl/ffs.sv
// ffs: constant-time (a - b) mod P over 256 bits, one 64-bit limb per cycle through a single shared datapath
module ffs
  import ffs_pkg::*;
#(
  parameter logic [W-1:0] P = P_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] out,
  output logic         done
);
  state_e            state_q;
  logic [W-1:0]      a_q, b_q, d_q, out_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cy_q, bf_q, done_q;
  logic [7:0]        idx_d;
  logic [LIMB_W-1:0] x_d, y_d, r_d;
  logic              sub_d, co_d, last_d;
  // CORR always adds a limb of P or zero so timing never depends on the borrow
  always_comb begin
    idx_d = 8'(cnt_q) * 8'(LIMB_W);
    sub_d = state_q != CORR;
    last_d = cnt_q == CNT_W'(NLIMB - 1);
    x_d = sub_d ? a_q[idx_d +: LIMB_W] : d_q[idx_d +: LIMB_W];
    y_d = sub_d ? b_q[idx_d +: LIMB_W] : (bf_q ? P[idx_d +: LIMB_W] : '0);
  end
  limb_addsub u_limb (
    .sub_i(sub_d),
    .x_i  (x_d),
    .y_i  (y_d),
    .ci_i (cy_q),
    .s_o  (r_d),
    .co_o (co_d)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      d_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
      cy_q <= 1'b0;
      bf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          a_q <= a;
          b_q <= b;
          cnt_q <= '0;
          cy_q <= 1'b0;
          state_q <= SUB;
        end
        SUB: begin
          d_q[idx_d +: LIMB_W] <= r_d;
          cnt_q <= cnt_q + 1'b1;
          cy_q <= last_d ? 1'b0 : co_d;
          if (last_d) begin
            bf_q <= co_d;
            state_q <= CORR;
          end
        end
        CORR: begin
          d_q[idx_d +: LIMB_W] <= r_d;
          cnt_q <= cnt_q + 1'b1;
          cy_q <= last_d ? 1'b0 : co_d;
          if (last_d) begin
            out_q <= {r_d, d_q[W-LIMB_W-1:0]};
            done_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out = out_q;
  assign done = done_q;
endmodule

// File: tb/tb_ffs.sv
// tb_ffs: directed scoreboard bench for the modular subtractor
module tb_ffs;
  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  typedef struct {logic [255:0] v; int t;} exp_t;
  logic clk = 0, rst = 0, start = 0, prev_done = 0;
  logic [255:0] a = '0, b = '0;
  logic [255:0] out;
  logic done;
  int cyc = 0, compared = 0, mismatched = 0;
  exp_t q[$];

  ffs dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .out(out), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] model(input logic [255:0] x, input logic [255:0] y);
    logic [256:0] d;
    d = {1'b0, x} - {1'b0, y};
    return d[256] ? d[255:0] + P : d[255:0];
  endfunction

  always @(posedge clk) begin
    #1;
    if (done) begin
      chk("pulse_width", {255'd0, prev_done}, 256'd0);
      if (q.size() == 0) chk("spurious_done", 256'd1, 256'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out", out, e.v);
        chk("latency", 256'(cyc), 256'(e.t));
      end
    end
    prev_done = done;
  end

  task automatic launch(input logic [255:0] x, input logic [255:0] y, input logic [255:0] ev, output int t0);
    @(negedge clk);
    a = x;
    b = y;
    start = 1;
    @(posedge clk);
    #1;
    t0 = cyc;
    q.push_back('{ev, t0 + 8});
    @(negedge clk);
    start = 0;
    a = ~x;
    b = {y[127:0], y[255:128]};
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk(tag, 256'(q.size()), 256'd0);
  endtask

  task automatic op(input logic [255:0] x, input logic [255:0] y, input logic [255:0] ev, input string tag);
    int t0;
    launch(x, y, ev, t0);
    drain(tag);
  endtask

  initial begin
    int t0;
    logic [255:0] x, y;
    repeat (2) @(negedge clk);
    chk("reset_out", out, 256'd0);
    chk("reset_done", {255'd0, done}, 256'd0);
    rst = 1;
    op(256'd5, 256'd3, 256'd2, "op_5_3");
    op(256'd3, 256'd5, P - 256'd2, "op_3_5");
    op(P - 256'd1, P - 256'd1, 256'd0, "op_pm1_pm1");
    op(256'd0, P - 256'd1, 256'd1, "op_0_pm1");
    op(256'd1 << 64, 256'd1, 256'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, "op_borrow");
    for (int i = 0; i < 4; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      y = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (x >= P) x = x - P;
      if (y >= P) y = y - P;
      op(x, y, model(x, y), "op_rand");
    end
    // busy: second request at T0+3 must be dropped
    launch(256'd9, 256'd4, 256'd5, t0);
    while (cyc < t0 + 2) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    drain("busy_ignored");
    // held start: one launch every 9 cycles
    @(negedge clk);
    a = 256'd10;
    b = 256'd4;
    start = 1;
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int k = 0; k < 3; k++) q.push_back('{256'd6, t0 + 8 + 9 * k});
    while (cyc < t0 + 20) @(negedge clk);
    start = 0;
    drain("held_start");
    // reset mid-operation abandons it
    launch(256'd100, 256'd1, 256'd99, t0);
    void'(q.pop_back());
    while (cyc < t0 + 4) @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("midreset_out", out, 256'd0);
    chk("midreset_done", {255'd0, done}, 256'd0);
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (12) @(negedge clk);
    chk("midreset_quiet", out, 256'd0);
    op(256'd7, 256'd2, 256'd5, "op_after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "timeout");
  end
endmodule
